// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a consecutive-sample debounce FSM.
// Produces a clean level plus one-cycle rise/fall pulses; all outputs registered.
module input_debouncer #(
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt;
    state_t               r_state;
    logic                 r_dout;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_busy;

    // Metastability synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: a candidate level must persist for DEBOUNCE_CNT samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2 != r_dout) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (r_sync2 == r_dout) begin
                        // Bounced back before qualifying: drop the candidate silently.
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_dout  <= r_sync2;
                        r_rise  <= r_sync2;
                        r_fall  <= ~r_sync2;
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_state <= ST_COUNT;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule
